// File: rtl/pc_img_frame_buffer.sv
// pc_img_frame_buffer: PC-image frame store and grayscale streamer.
// The UART receive path writes one RGB565 frame. A start trigger with the PC
// source selected streams the frame in raster order as 8-bit grayscale over
// valid/ready. Each beat carries start-of-frame, end-of-line and end-of-frame
// tags.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   pc_img_fb_we      pixel write strobe
//   pc_img_fb_wAddr   raster write address; out-of-range writes are dropped
//   pc_img_fb_wData   RGB565 pixel
//   start_edge_trig   single-cycle start pulse
//   edge_input_sel    source select; 1 = PC, the only source that starts a stream
//   m_valid/m_ready   output handshake
//   m_data            grayscale pixel
//   m_sof/m_eol/m_eof frame/line tags, qualified by m_valid
//   busy              stream in progress
//   frame_done        one-cycle pulse after the final beat is accepted
//   wr_overrun        sticky flag for a write dropped while busy
//
// Optional build macro: FB_WR_LOCK_EN. When it is defined, writes are blocked
// while busy and wr_overrun is raised. When it is undefined, writes always
// land and wr_overrun is tied to 0.
module pc_img_frame_buffer #(
  parameter int unsigned IMG_WIDTH  = 176,
  parameter int unsigned IMG_HEIGHT = 240,
  parameter int unsigned ADDR_WIDTH = $clog2(IMG_WIDTH * IMG_HEIGHT),
  parameter int unsigned PIX_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pc_img_fb_we,
  input  logic [ADDR_WIDTH-1:0] pc_img_fb_wAddr,
  input  logic [PIX_WIDTH-1:0]  pc_img_fb_wData,
  input  logic                  start_edge_trig,
  input  logic                  edge_input_sel,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [7:0]            m_data,
  output logic                  m_sof,
  output logic                  m_eol,
  output logic                  m_eof,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  wr_overrun
);

  localparam int unsigned NPIX  = IMG_WIDTH * IMG_HEIGHT;
  localparam int unsigned COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int unsigned ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NPIX - 1);
  localparam logic [COL_W-1:0]      LAST_COL  = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0]      LAST_ROW  = ROW_W'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2
  } state_e;

  typedef struct packed {
    logic [7:0] data;
    logic       sof;
    logic       eol;
    logic       eof;
  } beat_t;

  state_e                  state_q, state_d;
  logic                    start_acc, issue, last_pop;
  logic [ADDR_WIDTH-1:0]   rd_addr_q;
  logic [COL_W-1:0]        col_q;
  logic [ROW_W-1:0]        row_q;
  logic                    busy_q, frame_done_q;

  logic [PIX_WIDTH-1:0]    mem_q [NPIX];
  logic [PIX_WIDTH-1:0]    rdata_q;
  logic                    rvalid_q;
  logic [2:0]              rtag_q;
  logic                    addr_ok, wr_en;

  beat_t                   fifo_q [2];
  logic                    wr_ptr_q, rd_ptr_q;
  logic [1:0]              cnt_q;
  logic                    fifo_nonempty, pop, push, fifo_pop, can_issue;
  logic [2:0]              occ_after;

  logic [7:0]              r8, g8, b8;
  logic [15:0]             y_sum;
  beat_t                   stage_beat, head;

  // Frame store: write port from UART, 1-cycle read port. Read-first on collision.
  assign addr_ok = (32'(pc_img_fb_wAddr) < NPIX);

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[pc_img_fb_wAddr] <= pc_img_fb_wData;
    if (issue) rdata_q <= mem_q[rd_addr_q];
  end

  // RGB565 -> 8-bit luma on RAM read data. The max sum 256*255 fits in 16 bits.
  always_comb begin
    r8    = {rdata_q[15:11], rdata_q[15:13]};
    g8    = {rdata_q[10:5],  rdata_q[10:9]};
    b8    = {rdata_q[4:0],   rdata_q[4:2]};
    y_sum = 16'd77 * 16'(r8) + 16'd150 * 16'(g8) + 16'd29 * 16'(b8);
    stage_beat.data = y_sum[15:8];
    stage_beat.sof  = rtag_q[2];
    stage_beat.eol  = rtag_q[1];
    stage_beat.eof  = rtag_q[0];
  end

  // The output head is the oldest skid entry. When the skid buffer is empty,
  // the beat just returned from RAM is presented directly, which gives the
  // 2-cycle trigger-to-valid latency.
  assign fifo_nonempty = (cnt_q != 2'd0);
  assign head          = fifo_nonempty ? fifo_q[rd_ptr_q] : stage_beat;
  assign m_valid       = fifo_nonempty | rvalid_q;
  assign pop           = m_valid & m_ready;
  assign fifo_pop      = pop & fifo_nonempty;
  assign push          = rvalid_q & ~(pop & ~fifo_nonempty);

  // Occupancy plus the in-flight read, after this cycle's pop, must stay below 2.
  assign occ_after = 3'(cnt_q) + 3'(rvalid_q) - 3'(pop);
  assign can_issue = (occ_after < 3'd2);

  always_comb begin
    m_data = 8'd0;
    m_sof  = 1'b0;
    m_eol  = 1'b0;
    m_eof  = 1'b0;
    if (m_valid) begin
      m_data = head.data;
      m_sof  = head.sof;
      m_eol  = head.eol;
      m_eof  = head.eof;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_acc) state_d = S_STREAM;
      S_STREAM: if (issue && (rd_addr_q == LAST_ADDR)) state_d = S_DRAIN;
      S_DRAIN:  if (last_pop) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    start_acc = 1'b0;
    issue     = 1'b0;
    last_pop  = 1'b0;
    case (state_q)
      S_IDLE:   start_acc = start_edge_trig & edge_input_sel;
      S_STREAM: issue     = can_issue;
      S_DRAIN:  last_pop  = pop & head.eof;
      default:  ;
    endcase
  end

  // Read counters, tag pipeline, skid buffer and status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_addr_q    <= '0;
      col_q        <= '0;
      row_q        <= '0;
      rvalid_q     <= 1'b0;
      rtag_q       <= 3'b000;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      cnt_q        <= 2'd0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      busy_q       <= (state_d != S_IDLE);
      frame_done_q <= last_pop;
      rvalid_q     <= issue;
      if (start_acc) begin
        rd_addr_q <= '0;
        col_q     <= '0;
        row_q     <= '0;
      end else if (issue) begin
        rd_addr_q <= rd_addr_q + ADDR_WIDTH'(1);
        rtag_q    <= {(col_q == '0) && (row_q == '0),
                      (col_q == LAST_COL),
                      (col_q == LAST_COL) && (row_q == LAST_ROW)};
        if (col_q == LAST_COL) begin
          col_q <= '0;
          row_q <= row_q + ROW_W'(1);
        end else begin
          col_q <= col_q + COL_W'(1);
        end
      end
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (fifo_pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + 2'(push) - 2'(fifo_pop);
    end
  end

  // Skid storage needs no reset; it is qualified by cnt_q.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= stage_beat;
  end

  assign busy       = busy_q;
  assign frame_done = frame_done_q;

`ifdef FB_WR_LOCK_EN
  logic wr_overrun_q;

  // Frame is frozen while streaming; any attempted write flags an overrun.
  assign wr_en = pc_img_fb_we & addr_ok & ~busy_q;

  always_ff @(posedge clk) begin
    if (reset)                      wr_overrun_q <= 1'b0;
    else if (start_acc)             wr_overrun_q <= 1'b0;
    else if (pc_img_fb_we & busy_q) wr_overrun_q <= 1'b1;
  end

  assign wr_overrun = wr_overrun_q;
`else
  assign wr_en      = pc_img_fb_we & addr_ok;
  assign wr_overrun = 1'b0;
`endif

endmodule

// File: tb/tb_pc_img_frame_buffer.sv
// Self-checking bench for pc_img_frame_buffer, using a reduced 12x5 frame.
module tb_pc_img_frame_buffer;

  localparam int unsigned W  = 12;
  localparam int unsigned H  = 5;
  localparam int unsigned N  = W * H;
  localparam int unsigned AW = $clog2(N);
`ifdef FB_WR_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          we;
  logic [AW-1:0] waddr;
  logic [15:0]   wdata;
  logic          start;
  logic          sel;
  logic          m_valid, m_ready;
  logic [7:0]    m_data;
  logic          m_sof, m_eol, m_eof, busy, frame_done, wr_overrun;

  always #5 clk = ~clk;

  pc_img_frame_buffer #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk             (clk),
    .reset           (reset),
    .pc_img_fb_we    (we),
    .pc_img_fb_wAddr (waddr),
    .pc_img_fb_wData (wdata),
    .start_edge_trig (start),
    .edge_input_sel  (sel),
    .m_valid         (m_valid),
    .m_ready         (m_ready),
    .m_data          (m_data),
    .m_sof           (m_sof),
    .m_eol           (m_eol),
    .m_eof           (m_eof),
    .busy            (busy),
    .frame_done      (frame_done),
    .wr_overrun      (wr_overrun)
  );

  typedef struct {
    int          addr;
    logic [15:0] pix;
    logic [7:0]  exp;
  } vec_t;

  vec_t        tbl [9];
  logic [15:0] model [N];
  logic [7:0]  got [N];
  int          tests = 0;
  int          fails = 0;
  int          fc, lc;

  // Reference luma: channel expansion to 0..255, then weighted sum / 256.
  function automatic logic [7:0] gray(input logic [15:0] p);
    int r, g, b;
    r = int'(p[15:11]);
    g = int'(p[10:5]);
    b = int'(p[4:0]);
    r = r * 8 + r / 4;
    g = g * 4 + g / 16;
    b = b * 8 + b / 4;
    return 8'((77 * r + 150 * g + 29 * b) / 256);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Single write while idle; the model tracks only in-range addresses.
  task automatic wr(input int a, input logic [15:0] d);
    we    = 1'b1;
    waddr = AW'(a);
    wdata = d;
    step();
    we = 1'b0;
    if (a < int'(N)) model[a] = d;
  endtask

  // Trigger one frame and check every beat, stall holding, frame_done and busy.
  task automatic run_frame(input int ready_pct, input bit mid_trig, input int wr_at,
                           input int wr_a, input logic [15:0] wr_v, input bit ov_exp,
                           output int first_cyc, output int last_cyc);
    int          k, cyc;
    bit          fd_exp, fd_next, hold, fin;
    logic [10:0] hbeat;
    start   = 1'b1;
    sel     = 1'b1;
    m_ready = 1'b0;
    step();
    start = 1'b0;
    chk("busy_on", busy, 1);
    chk("valid_T1", m_valid, 0);
    chk("ovr_clear", wr_overrun, 0);
    k = 0; cyc = 1; fd_exp = 0; hold = 0; fin = 0; hbeat = '0;
    first_cyc = -1; last_cyc = -1;
    while (!fin && cyc < 20 * int'(N) + 100) begin
      we    = 1'b0;
      start = 1'b0;
      chk("frame_done", frame_done, 32'(fd_exp));
      if (fd_exp) begin
        chk("busy_off", busy, 0);
        chk("valid_off", m_valid, 0);
        fin = 1;
      end else begin
        if (hold) chk("hold", {m_valid, m_data, m_sof, m_eol, m_eof}, {1'b1, hbeat});
        if (m_valid && first_cyc < 0) first_cyc = cyc;
        m_ready = ($urandom_range(99) < ready_pct);
        if (mid_trig && cyc == int'(N) / 2) start = 1'b1;
        if (cyc == wr_at) begin
          we    = 1'b1;
          waddr = AW'(wr_a);
          wdata = wr_v;
          if (!LOCK) model[wr_a] = wr_v;
        end
        fd_next = 0;
        if (m_valid && m_ready) begin
          if (k < int'(N)) begin
            chk($sformatf("beat%0d", k), {m_data, m_sof, m_eol, m_eof},
                {gray(model[k]), k == 0, (k % int'(W)) == int'(W) - 1, k == int'(N) - 1});
            got[k] = m_data;
            if (k == int'(N) - 1) begin
              last_cyc = cyc;
              fd_next  = 1;
            end
          end else begin
            chk("extra_beat", k, N - 1);
          end
          k++;
        end
        hold   = m_valid && !m_ready;
        hbeat  = {m_data, m_sof, m_eol, m_eof};
        fd_exp = fd_next;
        step();
        cyc++;
      end
    end
    chk("frame_finished", 32'(fin), 1);
    chk("beat_count", k, N);
    chk("wr_overrun_end", wr_overrun, 32'(ov_exp));
    m_ready = 1'b1;
    repeat (3) begin
      step();
      chk("idle_valid", m_valid, 0);
      chk("idle_busy", busy, 0);
      chk("idle_done", frame_done, 0);
    end
  endtask

  initial begin
    tbl[0] = '{0,  16'hF800, 8'd76};
    tbl[1] = '{1,  16'h07E0, 8'd149};
    tbl[2] = '{2,  16'h001F, 8'd28};
    tbl[3] = '{3,  16'hFFFF, 8'd255};
    tbl[4] = '{4,  16'h0000, 8'd0};
    tbl[5] = '{5,  16'h8410, 8'd130};
    tbl[6] = '{6,  16'h1234, 8'd63};
    tbl[7] = '{11, 16'h0000, 8'd0};
    tbl[8] = '{59, 16'h8410, 8'd130};

    reset = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
    start = 1'b0; sel = 1'b0; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_sof", m_sof, 0);
    chk("rst_eol", m_eol, 0);
    chk("rst_eof", m_eof, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_ovr", wr_overrun, 0);
    reset = 1'b0;
    step();

    // Camera source selected: trigger must be ignored.
    start = 1'b1; sel = 1'b0; m_ready = 1'b1;
    step();
    start = 1'b0;
    repeat (4) begin
      chk("sel0_busy", busy, 0);
      chk("sel0_valid", m_valid, 0);
      step();
    end

    // All-white frame with table pixels, ready held high: exact timing.
    for (int a = 0; a < int'(N); a++) wr(a, 16'hFFFF);
    for (int i = 0; i < 9; i++) wr(tbl[i].addr, tbl[i].pix);
    run_frame(100, 0, -1, 0, 16'h0, 0, fc, lc);
    chk("first_valid_cyc", fc, 2);
    chk("last_beat_cyc", lc, N + 1);
    for (int i = 0; i < 9; i++)
      chk($sformatf("tbl%0d", i), got[tbl[i].addr], tbl[i].exp);

    // Ramp, out-of-range writes ignored, random backpressure, retrigger mid-stream.
    for (int a = 0; a < int'(N); a++) wr(a, 16'(a * 1031));
    wr(N, 16'h0000);
    wr((1 << AW) - 1, 16'h0000);
    run_frame(50, 1, -1, 0, 16'h0, 0, fc, lc);
    chk("first_valid_cyc_bp", fc, 2);

    // Write to a not-yet-read address while streaming.
    run_frame(100, 0, 5, 5, ~model[5], LOCK, fc, lc);

    // Random pixels under heavy backpressure; overrun cleared by this trigger.
    for (int a = 0; a < int'(N); a++) wr(a, 16'($urandom));
    run_frame(30, 0, -1, 0, 16'h0, 0, fc, lc);

    // Reset mid-stream: abandoned frame, no frame_done.
    start = 1'b1; sel = 1'b1; m_ready = 1'b1;
    step();
    start = 1'b0;
    repeat (20) step();
    chk("pre_rst_valid", m_valid, 1);
    reset = 1'b1;
    step();
    chk("mrst_valid", m_valid, 0);
    chk("mrst_data", m_data, 0);
    chk("mrst_tags", {m_sof, m_eol, m_eof}, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", frame_done, 0);
    chk("mrst_ovr", wr_overrun, 0);
    reset = 1'b0;
    repeat (6) begin
      step();
      chk("post_rst_done", frame_done, 0);
      chk("post_rst_valid", m_valid, 0);
      chk("post_rst_busy", busy, 0);
    end

    // Full frame after reset recovery.
    run_frame(70, 0, -1, 0, 16'h0, 0, fc, lc);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
